// File: rtl/bitops_pkg.sv
// Shared opcode/state types and width helper for the bitops_unit execution unit.
package bitops_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOT  = 4'd3,
    OP_ANDN = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHRA = 4'd7,
    OP_ROL  = 4'd8,
    OP_ROR  = 4'd9
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] OP_LAST_LOGIC = 4'd4;
  localparam logic [3:0] OP_LAST_SHIFT = 4'd9;

  function automatic int shamt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bitops_shift_step.sv
// Combinational single-iteration shifter/rotator: moves a WIDTH-bit value by
// 0..SHAMT_STEP bits in the direction/fill selected by op.
module bitops_shift_step
  import bitops_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHAMT_STEP = 1
) (
  input  op_e                               op,
  input  logic [WIDTH-1:0]                  value,
  input  logic [$clog2(SHAMT_STEP+1)-1:0]   amt,
  output logic [WIDTH-1:0]                  result
);

  localparam int AW = $clog2(SHAMT_STEP + 1);

  logic [WIDTH-1:0] cand [SHAMT_STEP+1];

  assign cand[0] = value;

  // One fixed-distance candidate per possible step; amt picks among them.
  genvar gi;
  generate
    for (gi = 1; gi <= SHAMT_STEP; gi++) begin : g_cand
      logic [WIDTH-1:0] rol_v;
      logic [WIDTH-1:0] ror_v;
      logic [WIDTH-1:0] sra_v;

      assign rol_v = (value << gi) | (value >> (WIDTH - gi));
      assign ror_v = (value >> gi) | (value << (WIDTH - gi));
      assign sra_v = $unsigned($signed(value) >>> gi);

      assign cand[gi] = (op == OP_SHL)  ? (value << gi) :
                        (op == OP_SHR)  ? (value >> gi) :
                        (op == OP_SHRA) ? sra_v :
                        (op == OP_ROL)  ? rol_v :
                        (op == OP_ROR)  ? ror_v : value;
    end
  endgenerate

  always_comb begin
    result = value;
    for (int k = 0; k <= SHAMT_STEP; k++) begin
      if (amt == AW'(k)) begin
        result = cand[k];
      end
    end
  end

endmodule

// File: rtl/bitops_unit.sv
// Multi-cycle bitwise/shift/rotate unit with start/busy/done handshake.
// Optional zero/neg result flags are built when BITOPS_FLAGS_EN is defined.
module bitops_unit
  import bitops_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHAMT_STEP = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] RZ
`ifdef BITOPS_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int SW = shamt_width(WIDTH);
  localparam int AW = $clog2(SHAMT_STEP + 1);

  state_e           state_reg;
  op_e              op_reg;
  logic [SW-1:0]    count_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] rz_reg;
  logic             busy_reg;
  logic             done_reg;

  op_e              op_in;
  logic [SW-1:0]    shamt;
  logic             is_logic;
  logic             is_shift;
  logic             last_step;
  logic [AW-1:0]    step_amt;
  logic [WIDTH-1:0] step_result;
  logic [WIDTH-1:0] logic_result;
  logic             rz_load;
  logic [WIDTH-1:0] rz_next;
  logic             unused_rb;

  assign op_in     = op_e'(op);
  assign shamt     = RB[SW-1:0];
  assign unused_rb = ^RB;
  assign is_logic  = (op <= OP_LAST_LOGIC);
  assign is_shift  = (op > OP_LAST_LOGIC) && (op <= OP_LAST_SHIFT);
  assign last_step = (int'(count_reg) <= SHAMT_STEP);

  always_comb begin
    if (int'(count_reg) >= SHAMT_STEP) begin
      step_amt = AW'(SHAMT_STEP);
    end else begin
      step_amt = AW'(count_reg);
    end
  end

  always_comb begin
    case (op_in)
      OP_AND:  logic_result = RA & RB;
      OP_OR:   logic_result = RA | RB;
      OP_XOR:  logic_result = RA ^ RB;
      OP_NOT:  logic_result = ~RA;
      OP_ANDN: logic_result = RA & ~RB;
      default: logic_result = '0;
    endcase
  end

  bitops_shift_step #(
    .WIDTH      (WIDTH),
    .SHAMT_STEP (SHAMT_STEP)
  ) u_shift_step (
    .op     (op_reg),
    .value  (work_reg),
    .amt    (step_amt),
    .result (step_result)
  );

  // A zero-distance shift completes immediately, like a logic op.
  always_comb begin
    rz_load = 1'b0;
    rz_next = '0;
    if (state_reg == ST_SHIFT) begin
      rz_load = last_step;
      rz_next = step_result;
    end else if (start && !(is_shift && (shamt != '0))) begin
      rz_load = 1'b1;
      rz_next = is_logic ? logic_result : (is_shift ? RA : '0);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_AND;
      count_reg <= '0;
      work_reg  <= '0;
      rz_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= rz_load;
      if (rz_load) begin
        rz_reg <= rz_next;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start && is_shift && (shamt != '0)) begin
            work_reg  <= RA;
            op_reg    <= op_in;
            count_reg <= shamt;
            busy_reg  <= 1'b1;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_reg  <= step_result;
          count_reg <= count_reg - SW'(step_amt);
          if (last_step) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef BITOPS_FLAGS_EN
  logic zero_reg;
  logic neg_reg;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
    end else if (rz_load) begin
      zero_reg <= (rz_next == '0);
      neg_reg  <= rz_next[WIDTH-1];
    end
  end

  assign zero = zero_reg;
  assign neg  = neg_reg;
`endif

  assign busy = busy_reg;
  assign done = done_reg;
  assign RZ   = rz_reg;

endmodule

// File: tb/tb_bitops_unit.sv
// Directed self-checking bench for bitops_unit (SHAMT_STEP 1 and 4 instances).
module tb_bitops_unit;
  import bitops_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] RA = '0;
  logic [W-1:0] RB = '0;
  logic         busy, done, busy4, done4;
  logic [W-1:0] RZ, RZ4;
`ifdef BITOPS_FLAGS_EN
  logic         zero, neg, zero4, neg4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bitops_unit #(.WIDTH(W), .SHAMT_STEP(1)) u_dut (
    .clock (clock), .clear (clear), .start (start), .op (op),
    .RA (RA), .RB (RB), .busy (busy), .done (done), .RZ (RZ)
`ifdef BITOPS_FLAGS_EN
    , .zero (zero), .neg (neg)
`endif
  );

  bitops_unit #(.WIDTH(W), .SHAMT_STEP(4)) u_dut4 (
    .clock (clock), .clear (clear), .start (start), .op (op),
    .RA (RA), .RB (RB), .busy (busy4), .done (done4), .RZ (RZ4)
`ifdef BITOPS_FLAGS_EN
    , .zero (zero4), .neg (neg4)
`endif
  );

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    RA    = a;
    RB    = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  // lat counts negedges from the sampling edge to the first done (-1 on timeout).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
    if (!done) lat = -1;
    $display("txn op=%0d RA=%h RB=%h -> RZ=%h lat=%0d busy_cycles=%0d", op, RA, RB, RZ, lat, bcnt);
  endtask

  task automatic test_reset();
    clear = 1'b0;
    #2 clear = 1'b1;
    #1;
    n_checks++; if (RZ !== 32'h0)  begin n_fail++; $display("FAIL reset_rz: got %h want %h", RZ, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef BITOPS_FLAGS_EN
    n_checks++; if (zero !== 1'b0 || neg !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", zero, neg); end
`endif
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_logic();
    int lat, bcnt;
    issue(4'd0, 32'hFFFF_FFFF, 32'h0);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0 || lat != 1 || bcnt != 0) begin n_fail++; $display("FAIL and_zero: got RZ=%h lat=%0d busy=%0d want 00000000 1 0", RZ, lat, bcnt); end
`ifdef BITOPS_FLAGS_EN
    n_checks++; if (zero !== 1'b1 || neg !== 1'b0) begin n_fail++; $display("FAIL flags_zero: got zero=%b neg=%b want 1 0", zero, neg); end
`endif
    issue(4'd0, 32'h1234_5678, 32'h8765_4321);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0224_4220 || lat != 1 || bcnt != 0) begin n_fail++; $display("FAIL and_mix: got RZ=%h lat=%0d busy=%0d want 02244220 1 0", RZ, lat, bcnt); end
    @(negedge clock);
    n_checks++; if (done !== 1'b0 || RZ !== 32'h0224_4220) begin n_fail++; $display("FAIL done_pulse: got done=%b RZ=%h want 0 02244220", done, RZ); end
    issue(4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'hFFFF_FFFF || lat != 1) begin n_fail++; $display("FAIL xor: got RZ=%h lat=%0d want ffffffff 1", RZ, lat); end
`ifdef BITOPS_FLAGS_EN
    n_checks++; if (zero !== 1'b0 || neg !== 1'b1) begin n_fail++; $display("FAIL flags_neg: got zero=%b neg=%b want 0 1", zero, neg); end
`endif
    issue(4'd3, 32'h0000_FFFF, 32'h1234_5678);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'hFFFF_0000) begin n_fail++; $display("FAIL not: got %h want ffff0000", RZ); end
    issue(4'd4, 32'hFF00_FF00, 32'hF0F0_F0F0);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0F00_0F00) begin n_fail++; $display("FAIL andn: got %h want 0f000f00", RZ); end
  endtask

  task automatic test_shra();
    int lat, bcnt, lat4;
    logic [W-1:0] rz4_cap;
    issue(4'd7, 32'h8000_0000, 32'd4);
    lat = 1; bcnt = 0; lat4 = -1; rz4_cap = '0;
    while (!done && lat < 200) begin
      if (done4 && lat4 < 0) begin lat4 = lat; rz4_cap = RZ4; end
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
    if (!done) lat = -1;
    $display("txn op=7 RA=80000000 RB=4 -> RZ=%h lat=%0d busy_cycles=%0d step4 RZ=%h lat=%0d", RZ, lat, bcnt, rz4_cap, lat4);
    n_checks++; if (RZ !== 32'hF800_0000 || lat != 5 || bcnt != 4) begin n_fail++; $display("FAIL shra_step1: got RZ=%h lat=%0d busy=%0d want f8000000 5 4", RZ, lat, bcnt); end
    n_checks++; if (rz4_cap !== 32'hF800_0000 || lat4 != 2) begin n_fail++; $display("FAIL shra_step4: got RZ=%h lat=%0d want f8000000 2", rz4_cap, lat4); end
    issue(4'd7, 32'h4000_0000, 32'd3);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0800_0000 || lat != 4) begin n_fail++; $display("FAIL shra_pos: got RZ=%h lat=%0d want 08000000 4", RZ, lat); end
  endtask

  task automatic test_rotate_zero();
    int lat, bcnt;
    issue(4'd8, 32'h8000_0001, 32'd1);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0000_0003 || lat != 2 || bcnt != 1) begin n_fail++; $display("FAIL rol: got RZ=%h lat=%0d busy=%0d want 00000003 2 1", RZ, lat, bcnt); end
    issue(4'd9, 32'h0000_0001, 32'd31);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0000_0002 || lat != 32) begin n_fail++; $display("FAIL ror31: got RZ=%h lat=%0d want 00000002 32", RZ, lat); end
    issue(4'd5, 32'h0000_1234, 32'd32);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0000_1234 || lat != 1 || bcnt != 0) begin n_fail++; $display("FAIL shl_zero: got RZ=%h lat=%0d busy=%0d want 00001234 1 0", RZ, lat, bcnt); end
  endtask

  task automatic test_clear();
    int lat, bcnt, seen_done;
    issue(4'd5, 32'h1, 32'd20);
    // First busy cycle: pulse a competing start that must be ignored.
    start = 1'b1; op = 4'd1; RA = 32'hFF; RB = 32'h0;
    @(negedge clock);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL busy_ignore: got busy=%b done=%b want 1 0", busy, done); end
    @(negedge clock);
    clear = 1'b1;
    #1;
    n_checks++; if (RZ !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL clear_mid: got RZ=%h busy=%b done=%b want 00000000 0 0", RZ, busy, done); end
    @(negedge clock);
    clear = 1'b0;
    seen_done = 0;
    repeat (25) begin
      @(negedge clock);
      if (done || busy) seen_done++;
    end
    n_checks++; if (seen_done != 0 || RZ !== 32'h0) begin n_fail++; $display("FAIL after_clear_idle: got activity=%0d RZ=%h want 0 00000000", seen_done, RZ); end
    issue(4'd1, 32'h0F, 32'hF0);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0000_00FF || lat != 1) begin n_fail++; $display("FAIL or_after_clear: got RZ=%h lat=%0d want 000000ff 1", RZ, lat); end
    issue(4'd5, 32'h1, 32'h25);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0000_0020 || lat != 6 || bcnt != 5) begin n_fail++; $display("FAIL shl_rb_high: got RZ=%h lat=%0d busy=%0d want 00000020 6 5", RZ, lat, bcnt); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    issue(4'd12, 32'hDEAD_BEEF, 32'h1);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h0 || lat != 1) begin n_fail++; $display("FAIL reserved: got RZ=%h lat=%0d want 00000000 1", RZ, lat); end
    issue(4'd6, 32'h100, 32'd8);
    wait_done(lat, bcnt);
    n_checks++; if (RZ !== 32'h1 || lat != 9 || busy !== 1'b0) begin n_fail++; $display("FAIL shr: got RZ=%h lat=%0d busy=%b want 00000001 9 0", RZ, lat, busy); end
    issue(4'd2, 32'hA5, 32'hFF);
    $display("txn op=2 RA=000000a5 RB=000000ff -> RZ=%h done=%b (back-to-back)", RZ, done);
    n_checks++; if (done !== 1'b1 || RZ !== 32'h5A) begin n_fail++; $display("FAIL b2b: got done=%b RZ=%h want 1 0000005a", done, RZ); end
    @(negedge clock);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got done=%b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shra();
    test_rotate_zero();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
